// File: rtl/uvma_obi_trkr_pkg.sv
// Shared types for the OBI transaction tracker: stored request entry, A-channel FSM states
// and sticky error bit positions.
package uvma_obi_trkr_pkg;

  // Entry fields are sized for the widest supported bus; narrower instances zero-extend.
  localparam int unsigned ADDR_W_MAX = 64;
  localparam int unsigned BE_W_MAX   = 16;
  localparam int unsigned ID_W_MAX   = 16;

  typedef struct packed {
    logic [ADDR_W_MAX-1:0] addr;
    logic                  we;
    logic [BE_W_MAX-1:0]   be;
    logic [ID_W_MAX-1:0]   id;
  } uvma_obi_trkr_entry_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } uvma_obi_trkr_a_st_t;

  localparam int unsigned ERR_OVERFLOW      = 0;
  localparam int unsigned ERR_UNDERFLOW     = 1;
  localparam int unsigned ERR_ID_MISMATCH   = 2;
  localparam int unsigned ERR_REQ_DROP      = 3;
  localparam int unsigned ERR_ADDR_UNSTABLE = 4;
  localparam int unsigned NUM_ERRS          = 5;

endpackage

// File: rtl/uvma_obi_trkr_fifo.sv
// In-order FIFO of outstanding requests; a pop on a full FIFO frees the slot for a same-cycle push.
module uvma_obi_trkr_fifo
  import uvma_obi_trkr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  uvma_obi_trkr_entry_t       wdata_i,
  output uvma_obi_trkr_entry_t       rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  uvma_obi_trkr_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign rdata_c = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uvma_obi_trn_trkr.sv
// OBI transaction tracker: pairs each R-handshake with its in-order A-handshake, emits one
// registered annotated transaction per response and keeps sticky protocol-error flags.
module uvma_obi_trn_trkr
  import uvma_obi_trkr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               req,
  input  logic                               gnt,
  input  logic                               we,
  input  logic [ADDR_WIDTH-1:0]              addr,
  input  logic [DATA_WIDTH/8-1:0]            be,
  input  logic [ID_WIDTH-1:0]                aid,
  input  logic                               rvalid,
  input  logic                               rready,
  input  logic                               err,
  input  logic [DATA_WIDTH-1:0]              rdata,
  input  logic [ID_WIDTH-1:0]                rid,
  input  logic                               clr_errs,
  output logic                               trn_valid,
  output logic [ADDR_WIDTH-1:0]              trn_addr,
  output logic                               trn_we,
  output logic [DATA_WIDTH/8-1:0]            trn_be,
  output logic [ID_WIDTH-1:0]                trn_id,
  output logic [DATA_WIDTH-1:0]              trn_rdata,
  output logic                               trn_err,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_overflow,
  output logic                               err_underflow,
  output logic                               err_id_mismatch,
  output logic                               err_req_drop,
  output logic                               err_addr_unstable
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  uvma_obi_trkr_entry_t a_entry, head, lat_q, lat_d;
  uvma_obi_trkr_a_st_t  state_q, state_d;
  logic                 a_hs, r_hs, pop_ok, full, empty;
  logic                 drop_set, unstable_set;
  logic [NUM_ERRS-1:0]  err_q, err_d, err_set;

  logic                  trn_valid_q, trn_valid_d;
  logic [ADDR_WIDTH-1:0] trn_addr_q, trn_addr_d;
  logic                  trn_we_q, trn_we_d;
  logic [BE_W-1:0]       trn_be_q, trn_be_d;
  logic [ID_WIDTH-1:0]   trn_id_q, trn_id_d;
  logic [DATA_WIDTH-1:0] trn_rdata_q, trn_rdata_d;
  logic                  trn_err_q, trn_err_d;

  assign a_hs   = req && gnt;
  assign r_hs   = rvalid && rready;
  assign pop_ok = r_hs && !empty;

  assign a_entry = '{addr: ADDR_W_MAX'(addr), we: we, be: BE_W_MAX'(be), id: ID_W_MAX'(aid)};

  uvma_obi_trkr_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (a_hs),
    .pop_i   (r_hs),
    .wdata_i (a_entry),
    .rdata_c (head),
    .full_c  (full),
    .empty_c (empty),
    .count_o (outstanding)
  );

  // A-channel FSM: tracks a pending request until granted and checks its stability.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    drop_set     = 1'b0;
    unstable_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !gnt) begin
          state_d = WAIT_GNT;
          lat_d   = a_entry;
        end
      end
      WAIT_GNT: begin
        if (!req) begin
          drop_set = 1'b1;
          state_d  = IDLE;
        end else begin
          if (a_entry != lat_q) unstable_set = 1'b1;
          if (gnt) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: a new error in the clearing cycle keeps its flag set.
  always_comb begin
    err_set                    = '0;
    err_set[ERR_OVERFLOW]      = a_hs && full && !pop_ok;
    err_set[ERR_UNDERFLOW]     = r_hs && empty;
    err_set[ERR_ID_MISMATCH]   = pop_ok && (head.id != ID_W_MAX'(rid));
    err_set[ERR_REQ_DROP]      = drop_set;
    err_set[ERR_ADDR_UNSTABLE] = unstable_set;
    err_d = err_set | (err_q & ~{NUM_ERRS{clr_errs}});
  end

  always_comb begin
    trn_valid_d = pop_ok;
    trn_addr_d  = trn_addr_q;
    trn_we_d    = trn_we_q;
    trn_be_d    = trn_be_q;
    trn_id_d    = trn_id_q;
    trn_rdata_d = trn_rdata_q;
    trn_err_d   = trn_err_q;
    if (pop_ok) begin
      trn_addr_d  = ADDR_WIDTH'(head.addr);
      trn_we_d    = head.we;
      trn_be_d    = BE_W'(head.be);
      trn_id_d    = ID_WIDTH'(head.id);
      trn_rdata_d = rdata;
      trn_err_d   = err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      err_q       <= '0;
      trn_valid_q <= 1'b0;
      trn_addr_q  <= '0;
      trn_we_q    <= 1'b0;
      trn_be_q    <= '0;
      trn_id_q    <= '0;
      trn_rdata_q <= '0;
      trn_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      err_q       <= err_d;
      trn_valid_q <= trn_valid_d;
      trn_addr_q  <= trn_addr_d;
      trn_we_q    <= trn_we_d;
      trn_be_q    <= trn_be_d;
      trn_id_q    <= trn_id_d;
      trn_rdata_q <= trn_rdata_d;
      trn_err_q   <= trn_err_d;
    end
  end

  assign trn_valid         = trn_valid_q;
  assign trn_addr          = trn_addr_q;
  assign trn_we            = trn_we_q;
  assign trn_be            = trn_be_q;
  assign trn_id            = trn_id_q;
  assign trn_rdata         = trn_rdata_q;
  assign trn_err           = trn_err_q;
  assign err_overflow      = err_q[ERR_OVERFLOW];
  assign err_underflow     = err_q[ERR_UNDERFLOW];
  assign err_id_mismatch   = err_q[ERR_ID_MISMATCH];
  assign err_req_drop      = err_q[ERR_REQ_DROP];
  assign err_addr_unstable = err_q[ERR_ADDR_UNSTABLE];

endmodule

// File: doc/uvma_obi_trn_trkr.md
# uvma_obi_trn_trkr

Synthesizable OBI transaction tracker that sits directly upstream of the OBI assertion checker and OBI monitor. It observes raw A-channel (req/gnt) and R-channel (rvalid/rready) handshakes and keeps an in-order FIFO of outstanding requests. It pairs every response with its originating request and emits one registered, fully-annotated transaction per response. It also raises sticky protocol-error flags for the checker to assert on.

## Interface
Parameters:
- ADDR_WIDTH, 32, OBI address width
- DATA_WIDTH, 32, OBI data width; BE width = DATA_WIDTH/8
- ID_WIDTH, 1, aid/rid width (≥1)
- MAX_OUTSTANDING, 4, FIFO depth; power of two, ≥2

Ports:
- clk  in  1  sampling clock
- reset_n  in  1  asynchronous, active-low reset
- req, gnt, we  in  1  OBI A-channel
- addr  in  ADDR_WIDTH  OBI A-channel
- be  in  DATA_WIDTH/8  OBI A-channel
- aid  in  ID_WIDTH  OBI A-channel
- rvalid, rready, err  in  1  OBI R-channel (tie rready=1 when absent)
- rdata  in  DATA_WIDTH  OBI R-channel
- rid  in  ID_WIDTH  OBI R-channel
- clr_errs  in  1  synchronous clear of all sticky error flags
- trn_valid  out  1  one-cycle pulse: completed transaction
- trn_addr / trn_we / trn_be / trn_id  out  as A-channel  stored request fields
- trn_rdata / trn_err  out  DATA_WIDTH / 1  captured response fields
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
- err_overflow, err_underflow, err_id_mismatch, err_req_drop, err_addr_unstable  out  1  sticky flags

## Operation
- A-handshake = req && gnt; R-handshake = rvalid && rready.
- A-handshake pushes {addr, we, be, aid}. R-handshake pops the head entry.
- A-channel FSM, states IDLE and WAIT_GNT:
  - IDLE→WAIT_GNT when req && !gnt; latch addr/we/be/aid.
  - WAIT_GNT→IDLE on gnt.
  - In WAIT_GNT, req low sets err_req_drop and returns to IDLE.
  - In WAIT_GNT, any change of addr/we/be/aid versus the latched copy sets err_addr_unstable.
- Push and pop in the same cycle:
  - Not empty: both happen, occupancy unchanged. This includes the full case (pop frees the slot).
- Full and push with no pop: push dropped, err_overflow set.
- Empty and pop:
  - No trn_valid is produced; err_underflow set.
  - A same-cycle push is still performed; the pop is ignored.
- On a valid pop, compare rid with the stored aid; a mismatch sets err_id_mismatch. trn_valid still fires, with trn_id = stored aid.
- Sticky flags hold until clr_errs. If clr_errs coincides with a new error, the new error wins (flag stays set).
- Pointers wrap modulo MAX_OUTSTANDING; occupancy never exceeds MAX_OUTSTANDING.

## Timing
- Reset (async assert, sync deassert is the integrator's responsibility):
  - FIFO pointers = 0, outstanding = 0, FSM = IDLE.
  - All trn_* outputs = 0, all err_* = 0.
- Latency: R-handshake at edge N → trn_valid high for exactly one cycle after edge N, carrying the request fields and the rdata/err sampled at edge N.
- Back-to-back R-handshakes yield back-to-back trn_valid pulses. There are no bubbles and no back-pressure.
- outstanding updates the cycle after the handshake edge.
- Error flags assert the cycle after the offending edge.
- Reset mid-operation discards all outstanding entries. No trn_valid is emitted for them.

## Structure
- Package uvma_obi_trkr_pkg holds:
  - typedef uvma_obi_trkr_entry_t (packed addr/we/be/id).
  - enum uvma_obi_trkr_a_st_t {IDLE, WAIT_GNT}.
  - Error-index localparams.
- One sub-module: uvma_obi_trkr_fifo, a parameterized synchronous FIFO with push/pop/full/empty/count and an async active-low reset.
- FSM, comparison and output registers stay in the top.

## Test plan
- Single write, addr=0x1000, be=0xF, aid=1; gnt 2 cycles after req; rvalid 3 cycles after gnt → outstanding 1→0; one trn_valid with addr 0x1000, we=1, trn_id=1; no errors.
- Four reads granted back-to-back (addr 0x0,0x4,0x8,0xC), then rvalid for 4 consecutive cycles → 4 consecutive trn_valid pulses in order 0x0..0xC; outstanding peaks at 4.
- FIFO full (4 outstanding) and a 5th A-handshake with no pop → err_overflow=1, outstanding stays 4. Repeat with a same-cycle R-handshake → no error, outstanding stays 4.
- rvalid while outstanding=0 → err_underflow=1, no trn_valid; clr_errs → flag returns to 0 next cycle.
- req high, addr changes 0x20→0x24 before gnt → err_addr_unstable. Separately, req dropped before gnt → err_req_drop.
- Request aid=2, response rid=3 → trn_valid with trn_id=2, err_id_mismatch=1. Assert reset_n low with 2 outstanding → outstanding=0, all outputs 0 immediately.
